// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store sequencing controller for the multicycle RV32I core.
//            Takes one load/store request, checks funct3 legality and
//            alignment, runs the memory handshake with a bounded wait, and
//            returns formatted load data with a one-cycle done pulse.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req_i / ready_o        - request handshake (accepted when ready)
//            is_store_i, funct3_i,
//            addr_i, wdata_i        - request payload, sampled with req_i
//            done_o, err_o,
//            err_code_o, rdata_o    - completion status and load result
//            mem_*                  - memory port (registered strobes/address)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_byte_enable_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] C_ERR_OK   = 2'b00;
  localparam logic [1:0] C_ERR_MIS  = 2'b01;
  localparam logic [1:0] C_ERR_TMO  = 2'b10;
  localparam logic [1:0] C_ERR_ILL  = 2'b11;

  // Counter value on the last ACCESS cycle before a timeout is declared.
  localparam logic [CNT_W-1:0] C_TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  // Request decode (from the live inputs, used only at accept time)
  logic        w_illegal;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_off;

  assign w_off = addr_i[1:0];

  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = 32'h0;
    if (is_store_i) begin
      w_illegal = (funct3_i >= 3'b011);
    end else begin
      w_illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                  (funct3_i == 3'b111);
    end
    // funct3[1:0] gives the access size for every legal encoding.
    case (funct3_i[1:0])
      2'b01:   w_misal = w_off[0];
      2'b10:   w_misal = (w_off != 2'b00);
      default: w_misal = 1'b0;
    endcase
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata_i;
        end
      endcase
    end
  end

  // Load data formatting, driven by the latched request attributes
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_byte = 8'(mem_rdata_i >> {off_q, 3'b000});
    w_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_rdata_i;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          is_store_d = is_store_i;
          funct3_d   = funct3_i;
          off_d      = w_off;
          if (w_illegal) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = C_ERR_ILL;
          end else if (w_misal) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = C_ERR_MIS;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            addr_d  = {addr_i[31:2], 2'b00};
            rd_d    = ~is_store_i;
            wr_d    = is_store_i;
            be_d    = w_be;
            wdata_d = w_wdata;
          end
        end
      end

      S_ACCESS: begin
        // A response in the same cycle as the timeout takes priority.
        if (mem_resp_i) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          state_d    = S_DONE;
          done_d     = 1'b1;
          err_code_d = C_ERR_OK;
          if (!is_store_q) begin
            rdata_d = w_load;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == C_TMO_LAST)) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          state_d    = S_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          err_code_d = C_ERR_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= C_ERR_OK;
      rdata_q    <= 32'h0;
      addr_q     <= 32'h0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign ready_o           = (state_q == S_IDLE);
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign err_code_o        = err_code_q;
  assign rdata_o           = rdata_q;
  assign mem_address_o     = addr_q;
  assign mem_read_o        = rd_q;
  assign mem_write_o       = wr_q;
  assign mem_byte_enable_o = be_q;
  assign mem_wdata_o       = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking bench for lsu_ctrl: directed cases followed by
//            randomized load/store requests with random response delays,
//            compared against a behavioural model of the access rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int C_TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_resp = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rdata = 32'h0;

  lsu_ctrl #(
    .TIMEOUT_CYCLES(C_TMO),
    .CNT_W(16)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (req),
    .ready_o          (ready),
    .is_store_i       (is_store),
    .funct3_i         (funct3),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .done_o           (done),
    .err_o            (err),
    .err_code_o       (err_code),
    .rdata_o          (rdata),
    .mem_address_o    (mem_address),
    .mem_read_o       (mem_read),
    .mem_write_o      (mem_write),
    .mem_byte_enable_o(mem_byte_enable),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata),
    .mem_resp_i       (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference formatting of load data from the memory word
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = ((off >= 2) ? (rd >> 16) : rd) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // One complete request; dly = ACCESS cycle index in which mem_resp is given
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] rd,
                        input bit poke);
    int n;
    int off;
    int size;
    int lo;
    bit illegal;
    bit mis;
    logic [1:0]  exp_code;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] wbytes;
    bit fin;
    int k;

    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      chk_eq("ready_wait", {31'h0, ready}, 32'h1);
      return;
    end

    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; is_store = $urandom; funct3 = $urandom; addr = $urandom; wdata = $urandom;

    off  = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
    mis = !illegal && ((size == 2 && (off % 2) != 0) || (size == 4 && off != 0));

    if (illegal || mis) begin
      exp_code = illegal ? 2'b11 : 2'b01;
    end else begin
      lo = (size == 1) ? off : (size == 2) ? (off / 2) * 2 : 0;
      exp_be = 4'h0;
      exp_wd = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (!st || (i >= lo && i < lo + size)) exp_be[i] = 1'b1;
        wbytes = wd >> (8 * (i % size));
        exp_wd[8*i +: 8] = wbytes[7:0];
      end
      fin = 1'b0;
      k = 0;
      exp_code = 2'b00;
      while (!fin) begin
        chk_eq("strobe_rd", {31'h0, mem_read}, {31'h0, !st});
        chk_eq("strobe_wr", {31'h0, mem_write}, {31'h0, st});
        chk_eq("mem_addr", mem_address, {a[31:2], 2'b00});
        chk_eq("byte_en", {28'h0, mem_byte_enable}, {28'h0, exp_be});
        if (st) chk_eq("mem_wdata", mem_wdata, exp_wd);
        if (k == dly) begin
          mem_resp = 1'b1;
          mem_rdata = rd;
        end
        @(posedge clk);
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = $urandom;
        if (k == dly) begin
          exp_code = 2'b00;
          fin = 1'b1;
          if (!st) exp_rdata = fmt_load(f3, off, rd);
        end else if (k == C_TMO - 1) begin
          exp_code = 2'b10;
          fin = 1'b1;
        end
        k++;
      end
    end

    // DONE cycle
    chk_eq("done", {31'h0, done}, 32'h1);
    chk_eq("err", {31'h0, err}, {31'h0, (exp_code != 2'b00)});
    chk_eq("err_code", {30'h0, err_code}, {30'h0, exp_code});
    chk_eq("rdata", rdata, exp_rdata);
    chk_eq("strobes_off", {30'h0, mem_read, mem_write}, 32'h0);
    chk_eq("ready_in_done", {31'h0, ready}, 32'h0);
    if (poke) begin
      req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk_eq("idle_after", {29'h0, ready, done, mem_read | mem_write}, 32'h4);
  endtask

  initial begin
    logic [2:0] rf3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk_eq("rst_ready", {31'h0, ready}, 32'h1);
    chk_eq("rst_flags", {28'h0, done, err, mem_read, mem_write}, 32'h0);
    chk_eq("rst_code", {30'h0, err_code}, 32'h0);
    chk_eq("rst_rdata", rdata, 32'h0);
    chk_eq("rst_addr", mem_address, 32'h0);
    chk_eq("rst_be", {28'h0, mem_byte_enable}, 32'h0);
    chk_eq("rst_wdata", mem_wdata, 32'h0);

    // Directed cases
    run_op(1'b0, 3'b000, 32'h2003, 32'h0, 0, 32'h80FF_1234, 1'b0);
    chk_eq("lb_val", rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h2003, 32'h0, 0, 32'h80FF_1234, 1'b1);
    chk_eq("lbu_val", rdata, 32'h0000_0080);
    run_op(1'b1, 3'b001, 32'h1002, 32'h0000_ABCD, 2, 32'h0, 1'b0);
    chk_eq("sh_keep", rdata, 32'h0000_0080);
    run_op(1'b0, 3'b101, 32'h3002, 32'h0, 1, 32'h9876_0000, 1'b0);
    chk_eq("lhu_val", rdata, 32'h0000_9876);
    run_op(1'b0, 3'b001, 32'h3002, 32'h0, 0, 32'h9876_0000, 1'b0);
    chk_eq("lh_val", rdata, 32'hFFFF_9876);
    run_op(1'b0, 3'b010, 32'h3000, 32'h0, 0, 32'h9876_0000, 1'b0);
    chk_eq("lw_val", rdata, 32'h9876_0000);
    run_op(1'b0, 3'b010, 32'h1001, 32'h0, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b011, 32'h1000, 32'h0, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'b011, 32'h1000, 32'h0, 0, 32'h0, 1'b1);
    run_op(1'b0, 3'b010, 32'h4000, 32'h0, 10, 32'h1111_2222, 1'b0);
    run_op(1'b0, 3'b010, 32'h4000, 32'h0, C_TMO - 1, 32'h3333_4444, 1'b0);
    chk_eq("resp_last", rdata, 32'h3333_4444);

    // Reset in the middle of an access
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk_eq("pre_rst_rd", {31'h0, mem_read}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_eq("async_rd_drop", {31'h0, mem_read}, 32'h0);
    chk_eq("async_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    mem_resp = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      chk_eq("post_rst_quiet", {29'h0, ready, done, mem_read}, 32'h4);
    end
    chk_eq("post_rst_rdata", rdata, 32'h0);

    // Randomized requests
    for (int i = 0; i < 300; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      run_op(1'($urandom), rf3, $urandom, $urandom, int'($urandom_range(0, C_TMO + 1)),
             $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
